// File: rtl/activation_lanes_if.sv
// activation_lanes_if
//   Bundles the beat handshake, the result stream and the saturation flag of
//   the activation unit.
//   master : producer/consumer side (drives input beats, out_ready, sat_clr)
//   slave  : activation unit side (drives in_ready, out_valid, out_data, sat_flag)
//   Signals:
//     in_valid/in_ready   input beat handshake
//     in_mode             00 PASS, 01 RELU, 10 LEAKY, 11 LEAKY_DERIV
//     in_leak             signed leak factor shared by all lanes of the beat
//     in_data             LANES packed signed lanes, lane i at [i*DATA_W +: DATA_W]
//     out_valid/out_ready output beat handshake
//     out_data            results, same packing as in_data
//     sat_flag/sat_clr    sticky saturation flag and its synchronous clear
interface activation_lanes_if #(
  parameter int LANES  = 4,
  parameter int DATA_W = 16
);
  logic                    in_valid;
  logic                    in_ready;
  logic [1:0]              in_mode;
  logic [DATA_W-1:0]       in_leak;
  logic [LANES*DATA_W-1:0] in_data;
  logic                    out_valid;
  logic                    out_ready;
  logic [LANES*DATA_W-1:0] out_data;
  logic                    sat_flag;
  logic                    sat_clr;

  modport master (
    output in_valid, in_mode, in_leak, in_data, out_ready, sat_clr,
    input  in_ready, out_valid, out_data, sat_flag
  );

  modport slave (
    input  in_valid, in_mode, in_leak, in_data, out_ready, sat_clr,
    output in_ready, out_valid, out_data, sat_flag
  );
endinterface

// File: rtl/activation_lanes.sv
// activation_lanes
//   Multi-lane activation unit: PASS, ReLU, leaky ReLU or leaky-ReLU
//   derivative on LANES signed Q(DATA_W-FRAC_W).FRAC_W values per beat.
//   Two pipeline stages with valid/ready backpressure:
//     S1 holds the beat and the full-width products x*leak,
//     S2 holds the rounded, saturated, mode-selected result (drives out_data).
//   Ports:
//     clk  rising-edge clock
//     rst  asynchronous active-high reset; empties both stages
//     bus  activation_lanes_if.slave (handshakes, data, sat_flag/sat_clr)
module activation_lanes #(
  parameter int LANES  = 4,
  parameter int DATA_W = 16,
  parameter int FRAC_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  activation_lanes_if.slave   bus
);
  localparam int PW = 2 * DATA_W;
  localparam int RW = PW + 1;

  localparam logic signed [RW-1:0]   MAX_V  = {{(DATA_W+2){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [RW-1:0]   MIN_V  = {{(DATA_W+2){1'b1}}, {(DATA_W-1){1'b0}}};
  localparam logic signed [RW-1:0]   HALF_V = {{(RW-1){1'b0}}, 1'b1} << (FRAC_W - 1);
  localparam logic [DATA_W-1:0]      SAT_HI = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0]      SAT_LO = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0]      ONE_V  = {{(DATA_W-1){1'b0}}, 1'b1} << FRAC_W;

  typedef enum logic [1:0] {
    MODE_PASS  = 2'b00,
    MODE_RELU  = 2'b01,
    MODE_LEAKY = 2'b10,
    MODE_DERIV = 2'b11
  } mode_t;

  // Stage 1 registers
  logic                     s1_valid_r;
  mode_t                    s1_mode_r;
  logic [DATA_W-1:0]        s1_leak_r;
  logic signed [DATA_W-1:0] s1_x_r    [LANES];
  logic signed [PW-1:0]     s1_prod_r [LANES];

  // Stage 2 registers
  logic                     s2_valid_r;
  logic [LANES*DATA_W-1:0]  s2_data_r;
  logic                     sat_flag_r;

  // Combinational signals
  logic                     s1_adv_s;
  logic                     s2_adv_s;
  logic                     accept_s;
  logic signed [DATA_W-1:0] x_in_s    [LANES];
  logic signed [PW-1:0]     prod_in_s [LANES];
  logic signed [RW-1:0]     sum_s     [LANES];
  logic signed [RW-1:0]     shr_s     [LANES];
  logic [DATA_W-1:0]        leaky_s   [LANES];
  logic                     clamp_s   [LANES];
  logic [DATA_W-1:0]        lane_y_s  [LANES];
  logic [LANES*DATA_W-1:0]  y_s;
  logic                     beat_sat_s;

  // A full stage may move forward only if its successor frees up this cycle.
  assign s2_adv_s     = !s2_valid_r || bus.out_ready;
  assign s1_adv_s     = !s1_valid_r || s2_adv_s;
  assign bus.in_ready = !rst && s1_adv_s;
  assign accept_s     = bus.in_valid && bus.in_ready;

  assign bus.out_valid = s2_valid_r;
  assign bus.out_data  = s2_data_r;
  assign bus.sat_flag  = sat_flag_r;

  // Unpack input lanes and form the full-precision products x*leak.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      x_in_s[i]    = bus.in_data[i*DATA_W +: DATA_W];
      prod_in_s[i] = PW'(x_in_s[i]) * PW'($signed(bus.in_leak));
    end
  end

  // Stage 1 register: capture the accepted beat and its products.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_r <= 1'b0;
      s1_mode_r  <= MODE_PASS;
      s1_leak_r  <= '0;
      for (int i = 0; i < LANES; i++) begin
        s1_x_r[i]    <= '0;
        s1_prod_r[i] <= '0;
      end
    end else if (s1_adv_s) begin
      s1_valid_r <= accept_s;
      if (accept_s) begin
        s1_mode_r <= mode_t'(bus.in_mode);
        s1_leak_r <= bus.in_leak;
        for (int i = 0; i < LANES; i++) begin
          s1_x_r[i]    <= x_in_s[i];
          s1_prod_r[i] <= prod_in_s[i];
        end
      end
    end
  end

  // Round-half-up, saturate and select the per-lane result from stage 1.
  always_comb begin
    y_s        = '0;
    beat_sat_s = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      // One extra bit so the rounding add can never wrap.
      sum_s[i] = RW'(s1_prod_r[i]) + HALF_V;
      shr_s[i] = sum_s[i] >>> FRAC_W;
      if (shr_s[i] > MAX_V) begin
        leaky_s[i] = SAT_HI;
        clamp_s[i] = 1'b1;
      end else if (shr_s[i] < MIN_V) begin
        leaky_s[i] = SAT_LO;
        clamp_s[i] = 1'b1;
      end else begin
        leaky_s[i] = shr_s[i][DATA_W-1:0];
        clamp_s[i] = 1'b0;
      end

      case (s1_mode_r)
        MODE_PASS:  lane_y_s[i] = s1_x_r[i];
        MODE_RELU:  lane_y_s[i] = s1_x_r[i][DATA_W-1] ? '0 : s1_x_r[i];
        MODE_LEAKY: lane_y_s[i] = s1_x_r[i][DATA_W-1] ? leaky_s[i] : s1_x_r[i];
        MODE_DERIV: lane_y_s[i] = s1_x_r[i][DATA_W-1] ? s1_leak_r : ONE_V;
        default:    lane_y_s[i] = s1_x_r[i];
      endcase

      // Only a negative lane in LEAKY mode actually uses the clamped value.
      if ((s1_mode_r == MODE_LEAKY) && s1_x_r[i][DATA_W-1] && clamp_s[i]) begin
        beat_sat_s = 1'b1;
      end else begin
        beat_sat_s = beat_sat_s;
      end
      y_s[i*DATA_W +: DATA_W] = lane_y_s[i];
    end
  end

  // Stage 2 register: output beat; data is zeroed whenever the stage is empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid_r <= 1'b0;
      s2_data_r  <= '0;
    end else if (s2_adv_s) begin
      s2_valid_r <= s1_valid_r;
      s2_data_r  <= s1_valid_r ? y_s : '0;
    end
  end

  // Sticky saturation flag: a clamping beat entering S2 beats a same-cycle clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sat_flag_r <= 1'b0;
    end else if (s2_adv_s && s1_valid_r && beat_sat_s) begin
      sat_flag_r <= 1'b1;
    end else if (bus.sat_clr) begin
      sat_flag_r <= 1'b0;
    end
  end
endmodule

// File: tb/tb_activation_lanes.sv
// tb_activation_lanes
//   Directed tests of the activation unit (reset mid-stream, leaky rounding,
//   saturation/sticky flag, back-to-back modes, backpressure) followed by a
//   random valid/ready stream checked against an integer reference model.
module tb_activation_lanes;
  logic clk;
  logic rst;
  int   checks_r;
  int   errors_r;

  activation_lanes_if #(.LANES(4), .DATA_W(16)) bus ();

  activation_lanes #(.LANES(4), .DATA_W(16), .FRAC_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks_r++;
    if (got !== exp) begin
      errors_r++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_beat(input logic v, input logic [1:0] m, input logic [15:0] l, input logic [63:0] d);
    bus.in_valid = v;
    bus.in_mode  = m;
    bus.in_leak  = l;
    bus.in_data  = d;
  endtask

  // Pipeline must be empty and out_ready high.
  task automatic send_one(input string tag, input logic [1:0] m, input logic [15:0] l,
                          input logic [63:0] d, input logic [63:0] exp);
    set_beat(1'b1, m, l, d);
    tick();
    set_beat(1'b0, 2'b00, 16'h0000, 64'h0);
    check({tag, "_lat"}, {63'h0, bus.out_valid}, 64'h0);
    tick();
    check({tag, "_vld"}, {63'h0, bus.out_valid}, 64'h1);
    check({tag, "_dat"}, bus.out_data, exp);
    tick();
    check({tag, "_drain"}, {63'h0, bus.out_valid}, 64'h0);
    check({tag, "_zero"}, bus.out_data, 64'h0);
  endtask

  // Integer reference for one lane; s reports a clamp that was used.
  function automatic logic [15:0] ref_lane(input logic [1:0] m, input logic [15:0] xu,
                                           input logic [15:0] lu, output bit s);
    longint x, l, r;
    x = longint'($signed(xu));
    l = longint'($signed(lu));
    s = 1'b0;
    case (m)
      2'b00: return xu;
      2'b01: return (x < 0) ? 16'h0000 : xu;
      2'b10: begin
        if (x >= 0) return xu;
        r = (x * l + 64'sd128) >>> 8;
        if (r > 64'sd32767) begin s = 1'b1; return 16'h7FFF; end
        if (r < -64'sd32768) begin s = 1'b1; return 16'h8000; end
        return r[15:0];
      end
      default: return (x < 0) ? lu : 16'h0100;
    endcase
  endfunction

  function automatic logic [63:0] ref_beat(input logic [1:0] m, input logic [15:0] l,
                                           input logic [63:0] d, output bit s);
    logic [63:0] y;
    bit          ls;
    s = 1'b0;
    y = 64'h0;
    for (int i = 0; i < 4; i++) begin
      y[i*16 +: 16] = ref_lane(m, d[i*16 +: 16], l, ls);
      s = s | ls;
    end
    return y;
  endfunction

  logic [63:0] exp_q[$];

  // Streams nbeats beats; rnd selects random traffic, otherwise out_ready is low for hold cycles.
  task automatic run_stream(input string tag, input int nbeats, input int hold, input bit rnd,
                            input int max_cycles, output bit sat_m);
    int          sent, got, cyc;
    bit          vin, vrdy, acc, del, held_prev, s;
    logic [63:0] obs, held_val, e;
    logic [1:0]  cm;
    logic [15:0] cl;
    logic [63:0] cd;
    sent = 0; got = 0; cyc = 0; held_prev = 0; held_val = 64'h0; sat_m = 1'b0;
    exp_q.delete();
    cm = 2'b00; cl = 16'h0000; cd = {4{16'h0101}};
    if (rnd) begin
      cm = 2'($urandom_range(0, 3)); cl = 16'($urandom); cd = {$urandom, $urandom};
    end
    while (got < nbeats && cyc < max_cycles) begin
      vin  = (sent < nbeats) && (rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
      vrdy = rnd ? ($urandom_range(0, 2) != 0) : (cyc >= hold);
      set_beat(vin, cm, cl, cd);
      bus.out_ready = vrdy;
      #0;
      if (!rnd && hold >= 3 && cyc == 2) check({tag, "_in_ready_drop"}, {63'h0, bus.in_ready}, 64'h0);
      if (held_prev) begin
        check({tag, "_held_vld"}, {63'h0, bus.out_valid}, 64'h1);
        check({tag, "_held_dat"}, bus.out_data, held_val);
      end
      acc = vin && bus.in_ready;
      del = bus.out_valid && vrdy;
      obs = bus.out_data;
      held_prev = bus.out_valid && !vrdy;
      held_val  = obs;
      tick();
      if (del) begin
        got++;
        if (exp_q.size() == 0) check({tag, "_unexpected"}, obs, 64'hx);
        else check({tag, "_data"}, obs, exp_q.pop_front());
      end
      if (acc) begin
        e = ref_beat(cm, cl, cd, s);
        exp_q.push_back(e);
        sat_m = sat_m | s;
        sent++;
        if (rnd) begin
          cm = 2'($urandom_range(0, 3));
          cl = ($urandom_range(0, 3) == 0) ? 16'h7FFF : 16'($urandom);
          cd = {$urandom, $urandom};
        end else begin
          cd = {4{16'(16'h0101 * (sent + 1))}};
        end
      end
      cyc++;
    end
    set_beat(1'b0, 2'b00, 16'h0000, 64'h0);
    bus.out_ready = 1'b1;
    check({tag, "_count"}, 64'(got), 64'(nbeats));
    check({tag, "_left"}, 64'(exp_q.size()), 64'h0);
  endtask

  initial begin
    bit sat_m;
    checks_r = 0;
    errors_r = 0;
    rst = 1'b1;
    set_beat(1'b0, 2'b00, 16'h0000, 64'h0);
    bus.out_ready = 1'b1;
    bus.sat_clr   = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst_in_ready", {63'h0, bus.in_ready}, 64'h0);
    check("rst_out_valid", {63'h0, bus.out_valid}, 64'h0);
    check("rst_out_data", bus.out_data, 64'h0);
    check("rst_sat", {63'h0, bus.sat_flag}, 64'h0);
    rst = 1'b0;
    tick();
    check("rst_rel_in_ready", {63'h0, bus.in_ready}, 64'h1);

    // 1. Reset mid-stream with two beats in flight
    set_beat(1'b1, 2'b00, 16'h0000, 64'hAAAA_AAAA_AAAA_AAAA);
    tick();
    set_beat(1'b1, 2'b00, 16'h0000, 64'hBBBB_BBBB_BBBB_BBBB);
    tick();
    set_beat(1'b0, 2'b00, 16'h0000, 64'h0);
    check("mid_pre_vld", {63'h0, bus.out_valid}, 64'h1);
    rst = 1'b1;
    #1;
    check("mid_rst_vld", {63'h0, bus.out_valid}, 64'h0);
    check("mid_rst_dat", bus.out_data, 64'h0);
    check("mid_rst_sat", {63'h0, bus.sat_flag}, 64'h0);
    tick();
    rst = 1'b0;
    tick();
    check("mid_post_vld", {63'h0, bus.out_valid}, 64'h0);
    send_one("mid_next", 2'b00, 16'h0000, 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0);

    // 2. Leaky rounding
    send_one("leaky", 2'b10, 16'h0040, 64'hFFFF_0000_FE00_0200, 64'h0000_0000_FF80_0200);
    check("leaky_sat", {63'h0, bus.sat_flag}, 64'h0);

    // 3. Saturation and sticky flag
    send_one("sat", 2'b10, 16'h7FFF, 64'h0000_0000_0000_8001, 64'h0000_0000_0000_8000);
    check("sat_set", {63'h0, bus.sat_flag}, 64'h1);
    tick();
    tick();
    check("sat_sticky", {63'h0, bus.sat_flag}, 64'h1);
    bus.sat_clr = 1'b1;
    tick();
    bus.sat_clr = 1'b0;
    check("sat_clr", {63'h0, bus.sat_flag}, 64'h0);
    set_beat(1'b1, 2'b10, 16'h7FFF, 64'h0000_0000_0000_8001);
    tick();
    set_beat(1'b0, 2'b00, 16'h0000, 64'h0);
    bus.sat_clr = 1'b1;
    tick();
    bus.sat_clr = 1'b0;
    check("sat_set_wins", {63'h0, bus.sat_flag}, 64'h1);
    check("sat_set_wins_dat", bus.out_data, 64'h0000_0000_0000_8000);
    tick();
    bus.sat_clr = 1'b1;
    tick();
    bus.sat_clr = 1'b0;
    check("sat_clr2", {63'h0, bus.sat_flag}, 64'h0);

    // 4. Modes back-to-back, no bubbles
    set_beat(1'b1, 2'b00, 16'h0040, {4{16'hFD00}});
    tick();
    set_beat(1'b1, 2'b01, 16'h0040, {4{16'hFD00}});
    tick();
    check("mode_pass", bus.out_data, {4{16'hFD00}});
    set_beat(1'b1, 2'b10, 16'h0040, {4{16'hFD00}});
    tick();
    check("mode_relu_vld", {63'h0, bus.out_valid}, 64'h1);
    check("mode_relu", bus.out_data, 64'h0);
    set_beat(1'b1, 2'b11, 16'h0040, {4{16'hFD00}});
    tick();
    check("mode_leaky", bus.out_data, {4{16'hFF40}});
    set_beat(1'b0, 2'b00, 16'h0000, 64'h0);
    tick();
    check("mode_deriv", bus.out_data, {4{16'h0040}});
    tick();
    check("mode_drain", {63'h0, bus.out_valid}, 64'h0);
    send_one("deriv_pos", 2'b11, 16'h0040, {4{16'h0005}}, {4{16'h0100}});
    send_one("deriv_zero", 2'b11, 16'h0040, 64'h0, {4{16'h0100}});

    // 5. Backpressure
    run_stream("bp", 6, 4, 1'b0, 200, sat_m);
    tick();
    tick();

    // 6. Random valid/ready against the reference model
    bus.sat_clr = 1'b1;
    tick();
    bus.sat_clr = 1'b0;
    run_stream("rand", 3000, 0, 1'b1, 30000, sat_m);
    tick();
    tick();
    check("rand_sat", {63'h0, bus.sat_flag}, {63'h0, sat_m});
    check("rand_idle", {63'h0, bus.out_valid}, 64'h0);

    $display("Result: errors=%0d of %0d checks", errors_r, checks_r);
    $finish;
  end
endmodule
